// File: rtl/refraction_dir_arbiter_if.sv
// Bundle of the requester, refraction-unit and response buses around the
// refraction_dir_arbiter. Fixed, Fixed3 and FixedNorm3 are carried as raw
// bit vectors: one component is FIX_W bits, a 3-vector is 3*FIX_W bits with
// x in the most significant component.
//
// Handshake rule for every valid/ready pair on this interface: a transfer
// happens on a rising clock edge where both valid and ready are high; the
// valid side holds valid and its payload stable until that edge, and the
// ready side may raise or drop ready at any time.
interface refraction_dir_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int FIX_W   = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   // requester side
   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ-1:0][3*FIX_W-1:0] req_n;
   logic [NUM_REQ-1:0][3*FIX_W-1:0] req_i;
   logic [NUM_REQ-1:0][FIX_W-1:0]   req_eta;
   // refraction unit side
   logic                            ru_strobe;
   logic [3*FIX_W-1:0]              ru_n;
   logic [3*FIX_W-1:0]              ru_i;
   logic [FIX_W-1:0]                ru_eta;
   logic [3*FIX_W-1:0]              ru_r;
   logic                            ru_valid;
   // response side and status
   logic                            resp_valid;
   logic                            resp_ready;
   logic [ID_W-1:0]                 resp_id;
   logic [3*FIX_W-1:0]              resp_r;
   logic                            resp_timeout;
   logic                            busy;
   logic [15:0]                     done_count;

   // arbiter view
   modport slave (
      input  req_valid, req_n, req_i, req_eta, ru_r, ru_valid, resp_ready,
      output req_ready, ru_strobe, ru_n, ru_i, ru_eta,
             resp_valid, resp_id, resp_r, resp_timeout, busy, done_count
   );

   // environment view: requesters, refraction unit and response consumer
   modport master (
      output req_valid, req_n, req_i, req_eta, ru_r, ru_valid, resp_ready,
      input  req_ready, ru_strobe, ru_n, ru_i, ru_eta,
             resp_valid, resp_id, resp_r, resp_timeout, busy, done_count
   );
endinterface

// File: rtl/refraction_dir_arbiter.sv
// Round-robin arbiter sharing one multi-cycle RefractionDir unit among
// NUM_REQ requesters. One operation at a time: grant, latch operands, strobe
// the unit, wait for its valid (or time out), then hold the tagged result on
// the response bus until accepted. Results pass through bit-exact.
module refraction_dir_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64,
   parameter int FIX_W   = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      resetn,
   refraction_dir_arbiter_if.slave   bus,
   output logic [1:0]                o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   state_t             r_state;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_owner;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [15:0]        r_done_count;
   logic               r_strobe;
   logic [3*FIX_W-1:0] r_ru_n;
   logic [3*FIX_W-1:0] r_ru_i;
   logic [FIX_W-1:0]   r_ru_eta;
   logic               r_resp_valid;
   logic [3*FIX_W-1:0] r_resp_r;
   logic               r_resp_timeout;

   logic               w_grant_any;
   logic [ID_W-1:0]    w_grant_id;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_next_ptr;
   logic               w_fire;

   // Round-robin scan: first asserted request starting at r_rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx         = 0;
      w_grant_any = 1'b0;
      w_grant_id  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(r_rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_grant_any && bus.req_valid[ID_W'(idx)]) begin
            w_grant_any = 1'b1;
            w_grant_id  = ID_W'(idx);
         end
      end
   end

   // Grants are only offered while idle; the pointer moves past the winner.
   assign w_grant    = (r_state == S_IDLE && w_grant_any) ?
                       (NUM_REQ'(1) << w_grant_id) : '0;
   assign w_fire     = |(bus.req_valid & w_grant);
   assign w_next_ptr = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

   // Operation sequencer: all state and registered outputs live here.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= S_IDLE;
         r_rr_ptr       <= '0;
         r_owner        <= '0;
         r_wait_cnt     <= '0;
         r_done_count   <= '0;
         r_strobe       <= 1'b0;
         r_ru_n         <= '0;
         r_ru_i         <= '0;
         r_ru_eta       <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_r       <= '0;
         r_resp_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fire) begin
                  r_ru_n   <= bus.req_n[w_grant_id];
                  r_ru_i   <= bus.req_i[w_grant_id];
                  r_ru_eta <= bus.req_eta[w_grant_id];
                  r_owner  <= w_grant_id;
                  r_rr_ptr <= w_next_ptr;
                  r_strobe <= 1'b1;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_strobe   <= 1'b0;
               r_wait_cnt <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
               // A valid arriving on the timeout cycle still wins.
               if (bus.ru_valid) begin
                  r_resp_r       <= bus.ru_r;
                  r_resp_timeout <= 1'b0;
                  r_resp_valid   <= 1'b1;
                  r_state        <= S_RESP;
               end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_resp_r       <= '0;
                  r_resp_timeout <= 1'b1;
                  r_resp_valid   <= 1'b1;
                  r_state        <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_done_count <= r_done_count + 16'd1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready    = w_grant;
   assign bus.ru_strobe    = r_strobe;
   assign bus.ru_n         = r_ru_n;
   assign bus.ru_i         = r_ru_i;
   assign bus.ru_eta       = r_ru_eta;
   assign bus.resp_valid   = r_resp_valid;
   assign bus.resp_id      = r_owner;
   assign bus.resp_r       = r_resp_r;
   assign bus.resp_timeout = r_resp_timeout;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done_count   = r_done_count;
   assign o_dbg_state      = r_state;

endmodule

// File: doc/refraction_dir_arbiter.md
# refraction_dir_arbiter

Shares one multi-cycle `RefractionDir` unit among `NUM_REQ` shading requesters with round-robin fairness. Operations run one at a time. For each granted request the arbiter:
- latches the operands (normal, incident direction, eta),
- pulses the unit's strobe,
- waits for the unit's valid, with a timeout guard,
- returns the refracted direction tagged with the requester id on a single valid/ready response bus.

It sits between the ray-shading cores and the refraction datapath.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 64, max cycles waited for unit valid after strobe (≥2).
- `ID_W`, `$clog2(NUM_REQ)`, requester id width.
- `clk` in 1: single clock; all state changes on rising edge.
- `resetn` in 1: reset is asynchronous and active-low; also drives the `RefractionDir` unit's `resetn`.
- `req_valid` in `NUM_REQ`: per-requester request.
- `req_ready` out `NUM_REQ`: one-hot grant; transfer when `req_valid[k] && req_ready[k]`.
- `req_n` in `NUM_REQ` x `FixedNorm3`: surface normals.
- `req_i` in `NUM_REQ` x `Fixed3`: incident directions.
- `req_eta` in `NUM_REQ` x `Fixed`: index ratios.
- `ru_strobe` out 1: unit start pulse.
- `ru_n` out `FixedNorm3`: operand to unit.
- `ru_i` out `Fixed3`: operand to unit.
- `ru_eta` out `Fixed`: operand to unit.
- `ru_r` in `Fixed3`: unit result.
- `ru_valid` in 1: unit result valid.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts response.
- `resp_id` out `ID_W`: requester that owns the response.
- `resp_r` out `Fixed3`: refracted direction.
- `resp_timeout` out 1: response produced by timeout; `resp_r` = 0.
- `busy` out 1: state != IDLE.
- `done_count` out 16: completed responses (incl. timeouts); wraps at 65535 → 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready` = one-hot of the first asserted `req_valid` scanning `rr_ptr`, `rr_ptr+1`, … mod `NUM_REQ` (combinational).
  - On handshake with requester k: latch `req_n[k]`, `req_i[k]`, `req_eta[k]` into `ru_*` registers; owner id ← k; `rr_ptr` ← (k+1) mod `NUM_REQ`; go to ISSUE.
  - No request: `req_ready` = 0; stay in IDLE.
- ISSUE: `ru_strobe` = 1 for exactly this cycle; clear `wait_cnt`; go to WAIT.
- WAIT:
  - `wait_cnt` increments each cycle.
  - `ru_valid` = 1: latch `ru_r` → `resp_r`, `resp_timeout` ← 0; go to RESP.
  - Else if `wait_cnt == TIMEOUT-1`: `resp_r` ← 0, `resp_timeout` ← 1; go to RESP.
  - `ru_valid` on the timeout cycle: valid wins.
- RESP:
  - `resp_valid` = 1, holding `resp_id`/`resp_r`/`resp_timeout` stable until `resp_ready`.
  - On `resp_ready`: `done_count`++; go to IDLE.
- `ru_valid` is ignored outside WAIT.
- `ru_n`/`ru_i`/`ru_eta` stay stable from ISSUE until the next grant.
- `req_ready` = 0 in every state except IDLE. A requester must hold `req_valid` and its operands until granted.
- Round-robin: a continuously requesting requester is granted within `NUM_REQ` operations.
- Result is passed through bit-exact; no arithmetic on operands or result.

## Timing
- Reset values (async on `resetn` low, held until release):
  - state IDLE, `rr_ptr` 0, owner id 0, `wait_cnt` 0, `done_count` 0;
  - `ru_strobe` 0, `ru_n`/`ru_i`/`ru_eta` 0;
  - `resp_valid` 0, `resp_id` 0, `resp_r` 0, `resp_timeout` 0, `busy` 0.
- Grant at edge t → `ru_strobe` high in cycle t+1.
- Unit valid at cycle t+1+L → `resp_valid` high from cycle t+2+L.
- Back-to-back ops: the next grant is possible in the cycle after the `resp_ready` handshake. Minimum occupancy = L+3 cycles.
- Reset mid-operation: the FSM returns to IDLE immediately; the in-flight op is dropped with no response and no count. The unit is reset by the same `resetn`.

## Test plan
- Single request, unit stub latency L=5: requester 2 sends N=(0,1,0) via `_FixedNorm3u`, I=(4294758429,4294876638,4294571145), ETA=15728.
  - `ru_strobe` is a 1-cycle pulse at t+1.
  - `resp_valid` at t+7 with `resp_id`=2, `resp_r` equal to the stub/`RefractionDir` output, `resp_timeout`=0, `done_count`=1.
- All 4 requesters hold `req_valid` continuously for 8 ops → grant order 0,1,2,3,0,1,2,3.
- Stub never asserts valid, `TIMEOUT`=64 → `resp_valid` 65 cycles after strobe with `resp_timeout`=1, `resp_r`=0.
- `resp_ready` held low 10 cycles → response fields stable; `req_ready` stays 0 for all; `done_count` increments only on accept.
- Stray `ru_valid` in IDLE/RESP → ignored, no state change. Valid coincident with the timeout cycle → `resp_timeout`=0 and result latched.
- `resetn` pulsed low during WAIT → all outputs at reset values asynchronously; no response emitted; the next request completes normally.
